axi_sram_bridge: RTL and testbench
==================================

// Module: axi_sram_bridge
// PURPOSE
//  AXI4 slave that turns AW/W/B and AR/R bursts into accesses on one native single-port
//  SRAM: addr, wdata, rdata, ena. The SRAM has synchronous read (1-cycle latency) and write-on-ena.
//  Sits directly upstream of the simulation DRAM/SRAM model. One burst owns the SRAM port at a time.
// PARAMETERS
//  AXI_AW   32  AXI byte-address width
//  WL_ADDR  8   SRAM word-address width (depth 2**WL_ADDR)
//  WL_DATA  32  data width, AXI and SRAM (multiple of 8)
//  ID_W     4   AXI ID width
// PORTS
//  clk        in   1        main clock
//  rst        in   1        asynchronous reset, active-low
//  s_awid/s_awaddr/s_awlen[7:0]/s_awburst[1:0]  in  ID_W/AXI_AW/8/2  write address
//  s_awvalid  in  1 ; s_awready  out  1          AW handshake
//  s_wdata    in   WL_DATA  write data (full-word only, no strobes)
//  s_wlast    in  1 ; s_wvalid  in  1 ; s_wready  out  1
//  s_bid      out  ID_W ; s_bresp  out  2 ; s_bvalid  out  1 ; s_bready  in  1
//  s_arid/s_araddr/s_arlen[7:0]/s_arburst[1:0]  in  ID_W/AXI_AW/8/2  read address
//  s_arvalid  in  1 ; s_arready  out  1
//  s_rid      out  ID_W ; s_rdata  out  WL_DATA ; s_rresp  out  2 ; s_rlast  out  1
//  s_rvalid   out  1 ; s_rready  in  1
//  sram_addr  out  WL_ADDR  SRAM word address
//  sram_wdata out  WL_DATA  SRAM write data
//  sram_ena   out  1        SRAM write enable
//  sram_rdata in   WL_DATA  SRAM registered read data
// BEHAVIOUR
//  - Reset (rst=0, async): FSM->IDLE; all ready/valid outputs 0; sram_ena 0; sram_addr 0; ids/resp 0.
//    An in-flight burst is dropped with no response.
//  - Word address = axaddr[LSB+WL_ADDR-1:LSB], LSB=log2(WL_DATA/8). Upper bits ignored.
//    INCR wraps mod 2**WL_ADDR. FIXED (00) holds the address. Burst 11 is treated as INCR.
//  - FSM states: IDLE, WR_DATA, WR_RESP, RD_ADDR, RD_DATA.
//  - IDLE: awready/arready asserted only for the granted side.
//    Both valid -> round-robin; the side not served last wins. After reset, write wins.
//    AW hs -> latch id/addr/len/burst, beat cnt=0 -> WR_DATA. AR hs -> latch -> RD_ADDR.
//  - WR_DATA: wready=1. sram_ena = wvalid (combinational), sram_addr = wr addr, sram_wdata = s_wdata.
//    One beat/cycle; addr/cnt advance on hs. Beat cnt==awlen -> WR_RESP.
//  - WR_RESP: bvalid=1 and holds until bready. bresp=00 OKAY, or 10 SLVERR if s_wlast disagreed with
//    (cnt==awlen) on any beat. Data is written regardless. Then -> IDLE.
//  - RD_ADDR: sram_addr = rd addr for one cycle (SRAM latches) -> RD_DATA.
//  - RD_DATA: rvalid=1; s_rdata=sram_rdata direct; rresp=00; rlast=(cnt==arlen).
//    sram_addr = hs ? next_addr : cur_addr (combinational), giving 1 beat/cycle with no bubble.
//    rvalid&&!rready holds addr, so rdata stays stable. Hs on last beat -> IDLE.
//  - Latency: AR hs edge E0 -> first rvalid after E1. W hs edge = SRAM write edge.
//  - sram_ena is never asserted outside WR_DATA. No write can disturb a read burst.
//  - len=0 bursts are single-beat. At beat 255, cnt must not overflow.
// CONFIGURATION
//  AXI_WRAP_BURST_EN defined: WRAP (10) with len in {1,3,7,15} wraps inside a (len+1)-word aligned
//    window: next = (a & ~len) | ((a+1) & len). Any other WRAP len -> INCR, SLVERR on B/R.
//  Not defined: WRAP is treated as INCR, resp OKAY.
// TESTING
//  1 AW addr=0x10 len=3 INCR, W D0..D3 back-to-back -> sram_ena 4 consecutive cycles at words
//    4..7; bresp=00, bid=awid.
//  2 AR addr=0x10 len=3 after test 1, rready=1 -> rdata D0..D3 in 4 consecutive cycles,
//    rlast only on 4th, first rvalid 2 cycles after AR hs.
//  3 Same read with rready toggling 1,0,0,1 -> rdata/rlast held stable while rready=0; no beat
//    lost or duplicated.
//  4 awvalid&arvalid together from reset -> write served first, then read; repeat -> read first.
//  5 AW len=1 with wlast on beat 0 -> both words written, bresp=10. Reset mid-burst -> all outputs 0.
//  6 With AXI_WRAP_BURST_EN: AR addr=0x18 (word 6) len=3 WRAP -> words 6,7,4,5.
//    Without the macro: words 6,7,8,9.

Source files
------------

// File: rtl/axi_sram_bridge.sv
// axi_sram_bridge: AXI4 slave serving one AW/W/B or AR/R burst at a time on a single-port SRAM.
// Define AXI_WRAP_BURST_EN to support WRAP bursts; otherwise WRAP behaves as INCR.
module axi_sram_bridge #(
  parameter int AXI_AW  = 32,
  parameter int WL_ADDR = 8,
  parameter int WL_DATA = 32,
  parameter int ID_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ID_W-1:0]    s_awid,
  input  logic [AXI_AW-1:0]  s_awaddr,
  input  logic [7:0]         s_awlen,
  input  logic [1:0]         s_awburst,
  input  logic               s_awvalid,
  output logic               s_awready,
  input  logic [WL_DATA-1:0] s_wdata,
  input  logic               s_wlast,
  input  logic               s_wvalid,
  output logic               s_wready,
  output logic [ID_W-1:0]    s_bid,
  output logic [1:0]         s_bresp,
  output logic               s_bvalid,
  input  logic               s_bready,
  input  logic [ID_W-1:0]    s_arid,
  input  logic [AXI_AW-1:0]  s_araddr,
  input  logic [7:0]         s_arlen,
  input  logic [1:0]         s_arburst,
  input  logic               s_arvalid,
  output logic               s_arready,
  output logic [ID_W-1:0]    s_rid,
  output logic [WL_DATA-1:0] s_rdata,
  output logic [1:0]         s_rresp,
  output logic               s_rlast,
  output logic               s_rvalid,
  input  logic               s_rready,
  output logic [WL_ADDR-1:0] sram_addr,
  output logic [WL_DATA-1:0] sram_wdata,
  output logic               sram_ena,
  input  logic [WL_DATA-1:0] sram_rdata
);
  localparam int LSB = $clog2(WL_DATA / 8);
  typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_ADDR, RD_DATA} state_t;
  state_t             state_q;
  logic [ID_W-1:0]    id_q;
  logic [WL_ADDR-1:0] addr_q, addr_d;
  logic [7:0]         len_q, cnt_q;
  logic [1:0]         burst_q;
  logic               err_q, last_rd_q;
  logic               aw_go, ar_go, w_hs, r_hs, last, aw_err, ar_err, unused_addr;
  assign unused_addr = ^{s_awaddr, s_araddr};
  // Round-robin: on contention the side not served last wins
  assign aw_go = state_q == IDLE && s_awvalid && (!s_arvalid || last_rd_q);
  assign ar_go = state_q == IDLE && s_arvalid && !aw_go;
  assign w_hs  = state_q == WR_DATA && s_wvalid;
  assign r_hs  = state_q == RD_DATA && s_rready;
  assign last  = cnt_q == len_q;
`ifdef AXI_WRAP_BURST_EN
  function automatic logic wrap_ok(input logic [7:0] l);
    return l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15;
  endfunction
  logic [WL_ADDR-1:0] wmask;
  assign wmask  = WL_ADDR'(len_q);
  assign aw_err = s_awburst == 2'b10 && !wrap_ok(s_awlen);
  assign ar_err = s_arburst == 2'b10 && !wrap_ok(s_arlen);
  assign addr_d = burst_q == 2'b00 ? addr_q :
                  (burst_q == 2'b10 && wrap_ok(len_q)) ? (addr_q & ~wmask) | ((addr_q + WL_ADDR'(1)) & wmask) :
                  addr_q + WL_ADDR'(1);
`else
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
  assign addr_d = burst_q == 2'b00 ? addr_q : addr_q + WL_ADDR'(1);
`endif
  // Readies are masked during reset so nothing is granted while rst is low
  assign s_awready  = rst && aw_go;
  assign s_arready  = rst && ar_go;
  assign s_wready   = state_q == WR_DATA;
  assign s_bvalid   = state_q == WR_RESP;
  assign s_bid      = id_q;
  assign s_bresp    = {err_q, 1'b0};
  assign s_rvalid   = state_q == RD_DATA;
  assign s_rid      = id_q;
  assign s_rdata    = sram_rdata;
  assign s_rresp    = {err_q, 1'b0};
  assign s_rlast    = s_rvalid && last;
  assign sram_ena   = w_hs;
  assign sram_wdata = s_wdata;
  // Presenting the next address on a read handshake keeps one beat per cycle
  assign sram_addr  = r_hs ? addr_d : addr_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      burst_q   <= '0;
      err_q     <= 1'b0;
      last_rd_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (aw_go) begin
            state_q   <= WR_DATA;
            id_q      <= s_awid;
            addr_q    <= s_awaddr[LSB +: WL_ADDR];
            len_q     <= s_awlen;
            burst_q   <= s_awburst;
            cnt_q     <= '0;
            err_q     <= aw_err;
            last_rd_q <= 1'b0;
          end else if (ar_go) begin
            state_q   <= RD_ADDR;
            id_q      <= s_arid;
            addr_q    <= s_araddr[LSB +: WL_ADDR];
            len_q     <= s_arlen;
            burst_q   <= s_arburst;
            cnt_q     <= '0;
            err_q     <= ar_err;
            last_rd_q <= 1'b1;
          end
        end
        WR_DATA: begin
          if (s_wvalid) begin
            addr_q <= addr_d;
            if (s_wlast != last) err_q <= 1'b1;
            if (last) state_q <= WR_RESP;
            else cnt_q <= cnt_q + 8'd1;
          end
        end
        WR_RESP: if (s_bready) state_q <= IDLE;
        RD_ADDR: state_q <= RD_DATA;
        RD_DATA: begin
          if (s_rready) begin
            addr_q <= addr_d;
            if (last) state_q <= IDLE;
            else cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_sram_bridge.sv
// tb_axi_sram_bridge: randomized AXI traffic against a transaction-level memory model,
// plus directed arbitration, backpressure, wlast-error, wrap and reset scenarios.
module tb_axi_sram_bridge;
`ifdef AXI_WRAP_BURST_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [3:0] s_awid = '0, s_arid = '0, s_bid, s_rid;
  logic [31:0] s_awaddr = '0, s_araddr = '0, s_wdata = '0, s_rdata, sram_wdata, sram_rdata = '0;
  logic [7:0] s_awlen = '0, s_arlen = '0, sram_addr;
  logic [1:0] s_awburst = '0, s_arburst = '0, s_bresp, s_rresp;
  logic s_awvalid = 0, s_awready, s_wlast = 0, s_wvalid = 0, s_wready, s_bvalid, s_bready = 0;
  logic s_arvalid = 0, s_arready, s_rlast, s_rvalid, s_rready = 0, sram_ena;

  axi_sram_bridge dut (
    .clk(clk), .rst(rst),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awburst(s_awburst),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arburst(s_arburst),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_ena(sram_ena), .sram_rdata(sram_rdata)
  );

  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (sram_ena) mem[sram_addr] <= sram_wdata;
    sram_rdata <= mem[sram_addr];
  end

  typedef struct {logic [7:0] a; logic [31:0] d;} wb_t;
  typedef struct {logic [3:0] id; logic [31:0] d; logic l; logic [1:0] r;} rb_t;
  typedef struct {logic [3:0] id; logic [1:0] r;} bb_t;
  wb_t qw[$];
  rb_t qr[$];
  bb_t qb[$];
  logic [31:0] ref_mem [256];
  logic [31:0] rd_got [256];
  int n_cmp = 0, n_bad = 0, run = 0, last_run = 0;
  logic [1:0] last_bresp = '0;
  logic hold = 0, hl = 0;
  logic [31:0] hd = '0;
  time aw_t, ar_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got no/unexpected DUT event, want the expected one", nm);
  endtask

  function automatic logic [7:0] mnext(input logic [7:0] a, input logic [7:0] len, input logic [1:0] b);
    int n = int'(len) + 1;
    int base = int'(a) - int'(a) % n;
    if (b == 2'b00) return a;
    if (WRAP_EN && b == 2'b10 && n inside {2, 4, 8, 16}) return 8'(base + (int'(a) + 1 - base) % n);
    return a + 8'd1;
  endfunction

  function automatic bit werr(input logic [1:0] b, input logic [7:0] len);
    return WRAP_EN && b == 2'b10 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
  endfunction

  always @(negedge clk) begin : mon
    wb_t w;
    rb_t r;
    bb_t b;
    if (!rst) begin
      hold = 0;
      run = 0;
    end else begin
      if (sram_ena) begin
        run++;
        if (qw.size() == 0) bad("wr_unexpected");
        else begin
          w = qw.pop_front();
          chk("wr_addr", sram_addr, w.a);
          chk("wr_data", sram_wdata, w.d);
        end
      end else if (run != 0) begin
        last_run = run;
        run = 0;
      end
      if (hold) begin
        chk("r_hold_valid", s_rvalid, 1);
        chk("r_hold_data", s_rdata, hd);
        chk("r_hold_last", s_rlast, hl);
      end
      hold = s_rvalid && !s_rready;
      hd = s_rdata;
      hl = s_rlast;
      if (s_rvalid && s_rready) begin
        if (qr.size() == 0) bad("r_unexpected");
        else begin
          r = qr.pop_front();
          chk("r_data", s_rdata, r.d);
          chk("r_last", s_rlast, r.l);
          chk("r_id", s_rid, r.id);
          chk("r_resp", s_rresp, r.r);
        end
      end
      if (s_bvalid && s_bready) begin
        last_bresp = s_bresp;
        if (qb.size() == 0) bad("b_unexpected");
        else begin
          b = qb.pop_front();
          chk("b_id", s_bid, b.id);
          chk("b_resp", s_bresp, b.r);
        end
      end
    end
  end

  task automatic wr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                    input logic [31:0] seed, input int bad_beat, input bit rnd);
    logic [7:0] a = addr[9:2];
    logic [31:0] d [256];
    logic err = werr(burst, len) || (bad_beat >= 0 && bad_beat <= int'(len));
    bit done = 0;
    int t = 0;
    wb_t w;
    bb_t b;
    for (int i = 0; i <= int'(len); i++) begin
      d[i] = seed != 0 ? seed + 32'(i) : $urandom;
      w.a = a;
      w.d = d[i];
      qw.push_back(w);
      ref_mem[a] = d[i];
      a = mnext(a, len, burst);
    end
    b.id = id;
    b.r = err ? 2'b10 : 2'b00;
    qb.push_back(b);
    @(posedge clk) #1;
    s_awid = id; s_awaddr = addr; s_awlen = len; s_awburst = burst; s_awvalid = 1;
    do begin @(negedge clk); t++; end while (!s_awready && t < 3000);
    if (!s_awready) begin bad("aw_timeout"); s_awvalid = 0; return; end
    aw_t = $time;
    for (int i = 0; i <= int'(len); i++) begin
      @(posedge clk) #1;
      s_awvalid = 0;
      if (rnd) while ($urandom % 3 == 0) begin s_wvalid = 0; @(posedge clk) #1; end
      s_wvalid = 1;
      s_wdata = d[i];
      s_wlast = (i == int'(len)) ^ (i == bad_beat);
      t = 0;
      do begin @(negedge clk); t++; end while (!s_wready && t < 3000);
      if (!s_wready) begin bad("w_timeout"); s_wvalid = 0; return; end
    end
    @(posedge clk) #1;
    s_wvalid = 0;
    s_wlast = 0;
    t = 0;
    while (!done && t < 3000) begin
      s_bready = rnd ? 1'($urandom % 2) : 1'b1;
      @(negedge clk);
      t++;
      done = s_bvalid && s_bready;
      @(posedge clk) #1;
    end
    if (!done) bad("b_timeout");
    s_bready = 0;
  endtask

  task automatic rd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                    input int mode);
    logic [7:0] a = addr[9:2];
    int k = 0, beats = 0, first = -1, t = 0;
    rb_t r;
    for (int i = 0; i <= int'(len); i++) begin
      r.id = id;
      r.d = ref_mem[a];
      r.l = i == int'(len);
      r.r = werr(burst, len) ? 2'b10 : 2'b00;
      qr.push_back(r);
      a = mnext(a, len, burst);
    end
    @(posedge clk) #1;
    s_arid = id; s_araddr = addr; s_arlen = len; s_arburst = burst; s_arvalid = 1;
    do begin @(negedge clk); t++; end while (!s_arready && t < 3000);
    if (!s_arready) begin bad("ar_timeout"); s_arvalid = 0; return; end
    ar_t = $time;
    while (beats <= int'(len) && k < 3000) begin
      @(posedge clk) #1;
      s_arvalid = 0;
      s_rready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom % 2) : (k % 4 == 1 || k % 4 == 0);
      @(negedge clk);
      k++;
      if (s_rvalid && first < 0) first = k;
      if (s_rvalid && s_rready) begin rd_got[beats] = s_rdata; beats++; end
    end
    chk("rd_first_latency", 64'(first), 64'd2);
    if (beats <= int'(len)) bad("r_timeout");
    @(posedge clk) #1;
    s_rready = 0;
  endtask

  initial begin
    #(900_000);
    $display("FAIL watchdog: got no finish, want finish before 900us");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp6 [4];
    logic [7:0] len;
    logic [1:0] burst;
    logic [31:0] addr;
    int bb, t;
    wb_t w;
`ifdef AXI_WRAP_BURST_EN
    exp6 = '{32'h6000_0002, 32'h6000_0003, 32'h6000_0000, 32'h6000_0001};
`else
    exp6 = '{32'h6000_0002, 32'h6000_0003, 32'h6000_0004, 32'h6000_0005};
`endif
    #2 rst = 0;
    s_awvalid = 1;
    s_arvalid = 1;
    @(negedge clk);
    chk("rst_awready", s_awready, 0);
    chk("rst_arready", s_arready, 0);
    chk("rst_bvalid", s_bvalid, 0);
    chk("rst_rvalid", s_rvalid, 0);
    chk("rst_sram_addr", sram_addr, 0);
    s_awvalid = 0;
    s_arvalid = 0;
    @(posedge clk) #1 rst = 1;
    // fill the whole SRAM; len 255 also probes the beat counter ceiling
    wr(4'h1, 32'h0, 8'd255, 2'b01, 0, -1, 0);
    rd(4'h2, 32'h400, 8'd255, 2'b01, 0);
    @(posedge clk) #1 rst = 0;
    @(posedge clk) #1 rst = 1;
    fork
      wr(4'h3, 32'h100, 8'd2, 2'b01, 0, -1, 0);
      rd(4'h4, 32'h200, 8'd2, 2'b01, 0);
    join
    chk("arb_write_first", aw_t < ar_t, 1);
    wr(4'h5, 32'h10, 8'd3, 2'b01, 32'hD000_0000, -1, 0);
    chk("t1_ena_run", last_run, 4);
    for (int i = 0; i < 4; i++) chk("t1_mem", mem[4 + i], 32'hD000_0000 + 32'(i));
    fork
      wr(4'h6, 32'h140, 8'd1, 2'b01, 0, -1, 1);
      rd(4'h7, 32'h240, 8'd1, 2'b01, 1);
    join
    chk("arb_read_first", ar_t < aw_t, 1);
    rd(4'h8, 32'h10, 8'd3, 2'b01, 0);
    for (int i = 0; i < 4; i++) chk("t2_rdata", rd_got[i], 32'hD000_0000 + 32'(i));
    rd(4'h9, 32'h10, 8'd3, 2'b01, 2);
    for (int i = 0; i < 4; i++) chk("t3_rdata", rd_got[i], 32'hD000_0000 + 32'(i));
    wr(4'hA, 32'h80, 8'd1, 2'b01, 32'h5500_0000, 0, 0);
    chk("t5_bresp", last_bresp, 2'b10);
    chk("t5_mem0", mem[32], 32'h5500_0000);
    chk("t5_mem1", mem[33], 32'h5500_0001);
    wr(4'hB, 32'h10, 8'd5, 2'b01, 32'h6000_0000, -1, 0);
    rd(4'hC, 32'h18, 8'd3, 2'b10, 0);
    for (int i = 0; i < 4; i++) chk("t6_wrap", rd_got[i], exp6[i]);
    for (int n = 0; n < 40; n++) begin
      addr = $urandom;
      burst = 2'($urandom % 4);
      case ($urandom % 6)
        0: len = 8'd0;
        1: len = 8'd1;
        2: len = 8'd3;
        3: len = 8'd7;
        4: len = 8'd15;
        default: len = 8'($urandom % 20);
      endcase
      bb = $urandom % 4 == 0 ? int'($urandom_range(int'(len))) : -1;
      wr(4'($urandom), addr, len, burst, 0, bb, 1);
      rd(4'($urandom), addr, len, burst, 1);
    end
    @(posedge clk) #1;
    s_awid = 4'hA; s_awaddr = 32'h40; s_awlen = 8'd3; s_awburst = 2'b01; s_awvalid = 1;
    t = 0;
    do begin @(negedge clk); t++; end while (!s_awready && t < 100);
    if (!s_awready) bad("rst_aw_timeout");
    w.a = 8'd16;
    w.d = 32'hBEEF_0000;
    qw.push_back(w);
    ref_mem[16] = 32'hBEEF_0000;
    @(posedge clk) #1;
    s_awvalid = 0; s_wvalid = 1; s_wdata = 32'hBEEF_0000; s_wlast = 0;
    @(negedge clk);
    @(posedge clk) #1;
    s_wdata = 32'hBEEF_0001; s_awvalid = 1; s_arvalid = 1;
    rst = 0;
    #1;
    chk("mid_rst_awready", s_awready, 0);
    chk("mid_rst_arready", s_arready, 0);
    chk("mid_rst_wready", s_wready, 0);
    chk("mid_rst_bvalid", s_bvalid, 0);
    chk("mid_rst_rvalid", s_rvalid, 0);
    chk("mid_rst_rlast", s_rlast, 0);
    chk("mid_rst_sram_ena", sram_ena, 0);
    chk("mid_rst_sram_addr", sram_addr, 0);
    chk("mid_rst_bid", s_bid, 0);
    chk("mid_rst_rid", s_rid, 0);
    chk("mid_rst_bresp", s_bresp, 0);
    chk("mid_rst_rresp", s_rresp, 0);
    @(posedge clk) #1;
    s_awvalid = 0; s_arvalid = 0; s_wvalid = 0;
    @(posedge clk) #1 rst = 1;
    chk("mid_rst_beat0", mem[16], 32'hBEEF_0000);
    chk("mid_rst_beat1_dropped", mem[17], ref_mem[17]);
    chk("mid_rst_w_pending", qw.size(), 0);
    wr(4'h3, 32'h44, 8'd0, 2'b01, 0, -1, 0);
    rd(4'h4, 32'h44, 8'd2, 2'b00, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
